alu_result_queue: RTL and testbench
===================================

# alu_result_queue

Result-side companion to the 4-bit ALU: accepts each ALU result (value, overflow error, opcode) through a valid/ready handshake and buffers it in a small in-order FIFO. It presents results to the writeback stage and maintains the architectural Z/V/N flag register and a saturating overflow-event counter, both updated as results are committed. It sits between the combinational ALU output and register-file writeback.

## Interface
- DATA_W, 4, width of ALU result
- DEPTH, 4, FIFO entries (power of two, ≥2)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ALU result present
- in_ready  out  1  queue can accept (= not full)
- in_opcode  in  2  00 ADD, 01 SUB, 10 NAND, 11 XOR
- in_result  in  DATA_W  ALU_Out value
- in_error  in  1  ALU overflow indication
- out_valid  out  1  head entry available
- out_ready  in  1  writeback consumes head
- out_result  out  DATA_W  head result
- out_error  out  1  head overflow (always 0 for NAND/XOR)
- out_opcode  out  2  head opcode
- flag_z  out  1  last committed result == 0
- flag_v  out  1  last committed ADD/SUB overflow
- flag_n  out  1  last committed ADD/SUB result MSB
- ovfl_count  out  8  committed overflow events, saturating
- clr_count  in  1  synchronous clear of ovfl_count

## Operation
- Push: in_valid && in_ready. Stored entry = {in_opcode, in_result, in_error & ~in_opcode[1]} (error masked for logical ops).
- Pop/commit: out_valid && out_ready. Entries leave strictly in arrival order.
- in_ready = (occupancy != DEPTH); combinational from occupancy only, never from in_valid/out_ready.
- out_valid = (occupancy != 0). out_result/out_error/out_opcode show head entry; stable while out_valid && !out_ready.
- No bypass: an entry pushed into an empty queue appears on out_* the following cycle.
- Simultaneous push and pop, 0 < occupancy < DEPTH: both occur, occupancy unchanged.
- Full: in_ready=0, push ignored even if out_ready=1 same cycle.
- Empty: out_ready ignored, no flag or counter change.
- Pointers wrap modulo DEPTH; occupancy 0..DEPTH inclusive (log2(DEPTH)+1 bits).
- Flag update on commit only:
  - ADD/SUB: Z ← (result==0), V ← error, N ← result[DATA_W-1].
  - NAND/XOR: Z ← (result==0); V, N hold.
- ovfl_count: +1 on commit of entry with error=1; holds at 255. clr_count same cycle wins (result 0, event dropped).

## Timing
- Reset (asserted asynchronously, any cycle): occupancy 0, pointers 0, flag_z/v/n 0, ovfl_count 0, out_valid 0, out_result/out_error/out_opcode 0, in_ready 1. In-flight entries discarded.
- Push-to-out_valid latency: 1 cycle. Commit-to-flag latency: flags/counter reflect committed entry on the cycle after the pop edge.
- Throughput: 1 push and 1 pop per cycle sustained.
- Release of rst: first push accepted at first rising edge with rst low.

## Test plan
- Reset mid-stream with 3 entries queued -> out_valid 0, in_ready 1, flags 0, ovfl_count 0 immediately (no clock edge needed).
- Push ADD 0111+0001 (result 1000, error 1), out_ready=1 -> next cycle out_result=1000, out_error=1; after commit Z=0, V=1, N=1, ovfl_count=1.
- Then commit XOR result 0000 -> Z=1, V=1, N=1 held; out_error=0 even if in_error driven 1.
- Fill with 4 pushes, out_ready=0 -> in_ready=0 after 4th; 5th push with in_valid=1 dropped; drain yields exactly the 4 values in order.
- Simultaneous push/pop at occupancy 2 for 10 cycles -> occupancy stays 2, order preserved across pointer wrap.
- 256 overflow commits -> ovfl_count=255 held; clr_count with concurrent overflow commit -> 0.

Source files
------------

// File: rtl/alu_result_queue.sv
// ============================================================================
// Module   : alu_result_queue
// Purpose  : In-order result FIFO between ALU and writeback with Z/V/N flag
//            register and saturating overflow-event counter updated on commit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_result_queue #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_opcode,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_error,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_error,
   output logic [1:0]        out_opcode,
   output logic              flag_z,
   output logic              flag_v,
   output logic              flag_n,
   output logic [7:0]        ovfl_count,
   input  logic              clr_count
);

   localparam int         AW      = $clog2(DEPTH);
   localparam int         CW      = AW + 1;
   localparam logic [7:0] CNT_MAX = 8'hFF;

   logic [DATA_W-1:0] r_mem_result [DEPTH];
   logic              r_mem_error  [DEPTH];
   logic [1:0]        r_mem_opcode [DEPTH];

   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;

   logic              w_push;
   logic              w_pop;
   logic [DATA_W-1:0] w_head_result;
   logic              w_head_error;
   logic [1:0]        w_head_opcode;
   logic              w_head_arith;

   assign in_ready  = (r_count != CW'(DEPTH));
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   assign w_head_result = r_mem_result[r_rd_ptr];
   assign w_head_error  = r_mem_error[r_rd_ptr];
   assign w_head_opcode = r_mem_opcode[r_rd_ptr];
   assign w_head_arith  = ~w_head_opcode[1];

   // Head is forced to zero when empty so stale storage never leaks out,
   // which also gives all-zero outputs right after reset.
   assign out_result = out_valid ? w_head_result : '0;
   assign out_error  = out_valid ? w_head_error  : 1'b0;
   assign out_opcode = out_valid ? w_head_opcode : 2'b00;

   // Storage needs no reset: entries are only observed while counted valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_result[r_wr_ptr] <= in_result;
         r_mem_error[r_wr_ptr]  <= in_error & ~in_opcode[1];
         r_mem_opcode[r_wr_ptr] <= in_opcode;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Logical ops only update Z; V and N keep the last arithmetic outcome.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_z <= 1'b0;
         flag_v <= 1'b0;
         flag_n <= 1'b0;
      end else if (w_pop) begin
         flag_z <= (w_head_result == '0);
         if (w_head_arith) begin
            flag_v <= w_head_error;
            flag_n <= w_head_result[DATA_W-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovfl_count <= 8'd0;
      end else if (clr_count) begin
         ovfl_count <= 8'd0;
      end else if (w_pop && w_head_error && (ovfl_count != CNT_MAX)) begin
         ovfl_count <= ovfl_count + 8'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_queue.sv
// ============================================================================
// Module   : tb_alu_result_queue
// Purpose  : Directed self-checking bench for alu_result_queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_result_queue;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_opcode;
   logic [3:0] in_result;
   logic       in_error;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_result;
   logic       out_error;
   logic [1:0] out_opcode;
   logic       flag_z;
   logic       flag_v;
   logic       flag_n;
   logic [7:0] ovfl_count;
   logic       clr_count;

   int tests_run = 0;
   int tests_failed = 0;

   alu_result_queue #(.DATA_W(4), .DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opcode  (in_opcode),
      .in_result  (in_result),
      .in_error   (in_error),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_error  (out_error),
      .out_opcode (out_opcode),
      .flag_z     (flag_z),
      .flag_v     (flag_v),
      .flag_n     (flag_n),
      .ovfl_count (ovfl_count),
      .clr_count  (clr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] fill_vals [4];
   logic [3:0] q [$];

   initial begin
      fill_vals[0] = 4'd3;
      fill_vals[1] = 4'd5;
      fill_vals[2] = 4'd9;
      fill_vals[3] = 4'd12;

      rst = 1'b1;
      in_valid = 1'b0;
      in_opcode = 2'b00;
      in_result = 4'd0;
      in_error = 1'b0;
      out_ready = 1'b0;
      clr_count = 1'b0;
      tick();
      tick();
      check("reset_out_valid", out_valid, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_flags", {flag_z, flag_v, flag_n}, 0);
      check("reset_count", ovfl_count, 0);
      check("reset_out_result", out_result, 0);
      rst = 1'b0;

      // ADD 0111+0001 -> 1000 with overflow
      in_valid = 1'b1; in_opcode = 2'b00; in_result = 4'b1000; in_error = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0; in_error = 1'b0;
      check("add_out_valid", out_valid, 1);
      check("add_out_result", out_result, 4'b1000);
      check("add_out_error", out_error, 1);
      tick();
      check("add_flags_zvn", {flag_z, flag_v, flag_n}, 3'b011);
      check("add_count", ovfl_count, 1);
      check("add_drained", out_valid, 0);

      // XOR result 0 with in_error driven high: error masked, V/N held
      in_valid = 1'b1; in_opcode = 2'b11; in_result = 4'b0000; in_error = 1'b1;
      tick();
      in_valid = 1'b0; in_error = 1'b0;
      check("xor_out_error", out_error, 0);
      check("xor_out_opcode", out_opcode, 2'b11);
      tick();
      check("xor_flags_zvn", {flag_z, flag_v, flag_n}, 3'b111);
      check("xor_count", ovfl_count, 1);

      // Fill to full with writeback stalled
      out_ready = 1'b0; in_opcode = 2'b00;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_result = fill_vals[i];
         tick();
      end
      check("full_in_ready", in_ready, 0);
      in_result = 4'd15;
      tick();
      in_valid = 1'b0;
      check("full_still_full", in_ready, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_order", out_result, fill_vals[i]);
         tick();
      end
      check("drain_empty", out_valid, 0);
      check("drain_flags_zvn", {flag_z, flag_v, flag_n}, 3'b001);

      // Occupancy 2 with concurrent push/pop across pointer wrap
      out_ready = 1'b0;
      q.delete();
      for (int i = 1; i <= 2; i++) begin
         in_valid = 1'b1; in_result = 4'(i);
         q.push_back(4'(i));
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_result = 4'(3 + i);
         check("stream_head", out_result, q[0]);
         check("stream_in_ready", in_ready, 1);
         tick();
         void'(q.pop_front());
         q.push_back(4'(3 + i));
      end
      in_valid = 1'b0;
      while (q.size() != 0) begin
         check("stream_tail", out_result, q[0]);
         tick();
         void'(q.pop_front());
      end
      check("stream_empty", out_valid, 0);

      // Clear alone
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      check("clr_alone", ovfl_count, 0);

      // 256 overflow commits saturate at 255
      in_opcode = 2'b01; in_result = 4'b1000; in_error = 1'b1;
      for (int i = 0; i < 256; i++) begin
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      check("sat_empty", out_valid, 0);
      check("sat_count", ovfl_count, 255);

      // Clear wins over concurrent overflow commit
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("clr_pending_error", out_error, 1);
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      check("clr_with_commit", ovfl_count, 0);
      check("clr_flags_zvn", {flag_z, flag_v, flag_n}, 3'b011);

      // Asynchronous reset with three entries queued
      out_ready = 1'b0; in_error = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("pre_rst_count", ovfl_count, 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_in_ready", in_ready, 1);
      check("async_rst_flags", {flag_z, flag_v, flag_n}, 0);
      check("async_rst_count", ovfl_count, 0);
      check("async_rst_out_result", out_result, 0);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_empty", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
